ahb_interconnect_arbiter: RTL and testbench
===========================================

# ahb_interconnect_arbiter

Multi-master AHB-Lite bus arbiter for the interconnect. It accepts bus requests from `NUM_MST` masters and issues a one-hot grant using round-robin priority. Handover is only allowed at burst boundaries or when a locked sequence ends. It drives the address-phase and data-phase master indices that steer the interconnect's address/control and write-data muxes, ahead of the address decode/compare logic.

## Interface
- `NUM_MST`, default 4, number of masters (2..16).
- `MW`, default `$clog2(NUM_MST)`, master index width.
- `DEF_MST`, default 0, default/park master index.

Ports:
- `hclk` input 1: bus clock, all state on rising edge.
- `hresetn` input 1: asynchronous active-low reset.
- `hbusreq` input NUM_MST: per-master bus request.
- `hlock` input NUM_MST: per-master locked-access request, valid with `hbusreq`.
- `htrans` input 2: muxed address-phase HTRANS of the current owner.
- `hburst` input 3: muxed address-phase HBURST of the current owner.
- `hready` input 1: bus HREADY, transfer-completion strobe.
- `hgrant` output NUM_MST: registered one-hot grant.
- `hmaster` output MW: address-phase owner index.
- `hmaster_d` output MW: data-phase owner index.
- `hmastlock` output 1: current address phase is locked.

## Operation
- Reset values:
  - `hgrant = 1 << DEF_MST`.
  - `hmaster = hmaster_d = DEF_MST`.
  - `hmastlock = 0`.
  - Round-robin pointer = `DEF_MST`.
  - Beat counter = 0.
  - FSM = PARK.
- Beat counter, updated on `hready & htrans==NONSEQ`:
  - SINGLE: 0.
  - INCR4/WRAP4: 3.
  - INCR8/WRAP8: 7.
  - INCR16/WRAP16: 15.
  - INCR: sets `undef_burst = 1`, counter 0.
- Beat counter, other cases:
  - `hready & htrans==SEQ`: decrement if nonzero.
  - `hready & htrans==IDLE`: clear counter and `undef_burst`.
  - BUSY: holds both.
- `arb_ok = hready & ~hold_lock & (htrans==IDLE | undef_burst_next | cnt_next==0)`.
  - `cnt_next` and `undef_burst_next` are the post-update values for this cycle.
- Round-robin pick: first requester scanning from `ptr+1` upward modulo `NUM_MST`.
  - With no requesters, the pick is `DEF_MST`.
  - On each grant change, `ptr <=` the new grantee.
- FSM states:
  - PARK: no requests and grant on `DEF_MST`.
    - Goes to OWNED on `arb_ok` when any `hbusreq` is set.
  - OWNED: a requester holds the grant.
    - Re-arbitrates on every `arb_ok`.
    - Goes to LOCKED if the granted master has `hlock` set at grant time.
    - Goes to PARK if, on `arb_ok`, no requests remain.
  - LOCKED: `hold_lock = 1` and the grant is frozen.
    - Exit requires the owner's `hlock = 0` and `arb_ok` (computed with `hold_lock` ignored), then behaves as OWNED.
- The grant is kept when the current owner wins the pick again, and `ptr` is unchanged in that case.
- `hmaster <= onehot2idx(hgrant)` when `hready`.
- `hmastlock <= hlock[granted] & LOCKED/entering` when `hready`.
- `hmaster_d <= hmaster` when `hready`.
- Masters may drop `hbusreq` at any time.
  - A fixed-length burst still completes: the grant is held until the counter expires.
- Unknown or X `htrans` is not handled; the bench must not drive it.

## Timing
- Grant latency: `hbusreq` sampled with `arb_ok` → `hgrant` valid next cycle.
  - The new owner's first address phase is accepted on the following `hready` edge (`hmaster` updates).
  - `hmaster_d` follows one accepted phase later.
- Minimum handover: 1 cycle from `arb_ok` to grant, plus 1 `hready` edge to address ownership.
- `hready = 0` freezes `hgrant`, `hmaster`, `hmaster_d`, `hmastlock` and the counters.
- Simultaneous `arb_ok` with requests from several masters: exactly one grant, by round-robin order.
- Last beat of a fixed burst (`cnt==1` and SEQ accepted) with another request pending: the grant moves on that edge.
- INCR burst: the grant may move on any accepted beat.
- Asynchronous reset mid-burst: all outputs return to reset values immediately, regardless of `hclk`.

## Structure
- Package `ahb_pkg`:
  - `htrans_e` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `hburst_e` (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
  - Function `burst_beats(hburst_e)` returning 0/3/7/15.
  - Arbiter FSM enum (PARK, OWNED, LOCKED).
- Sub-module `ahb_interconnect_rr_pick`: combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot pick and `any_req`.
- Top level: FSM, beat counter and the output registers.

## Test plan
- Reset with `hbusreq=0` → `hgrant=4'b0001`, `hmaster=0`, `hmastlock=0`; stays parked for 10 cycles.
- `hbusreq=4'b0110` held, every owner issues SINGLE NONSEQ with `hready=1` → grants rotate 2→1→2→1 after the first pick (ptr starts 0, so the first grant is master 1).
- Master 1 issues INCR8 while master 3 requests → `hgrant` stays `4'b0010` for all 8 accepted beats, moves to `4'b1000` on the edge accepting beat 8; `hmaster=3` at the next `hready`.
- Insert `hready=0` for 3 cycles mid-INCR4 → no output changes during the stall; the counter resumes and the grant moves only after 4 accepted beats.
- Master 2 asserts `hlock` across two SINGLE transfers with master 0 requesting → grant held, `hmastlock=1` for both address phases; after `hlock` drops and the IDLE is accepted, the grant goes to master 0 and `hmastlock=0`.
- Assert `hresetn=0` asynchronously mid-INCR16 owned by master 3 → outputs revert to reset values before the next `hclk` edge; arbitration restarts from PARK.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the interconnect arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWNED  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Beats remaining after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input hburst_e b);
    logic [3:0] n;
    n = '0;
    case (b)
      WRAP4,  INCR4:  n = 4'd3;
      WRAP8,  INCR8:  n = 4'd7;
      WRAP16, INCR16: n = 4'd15;
      default:        n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_interconnect_rr_pick.sv
// Combinational round-robin picker: first requester above the pointer, wrapping.
module ahb_interconnect_rr_pick #(
  parameter int NUM_MST = 4,
  parameter int MW      = $clog2(NUM_MST),
  parameter int DEF_MST = 0
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [MW-1:0]      i_ptr,
  output logic [NUM_MST-1:0] o_pick,
  output logic               o_any_req
);

  logic          w_found;
  logic [MW-1:0] w_idx;

  // Scan ptr+1 .. ptr+NUM_MST (the pointer itself last); park on DEF_MST when idle.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_MST; k++) begin
      w_idx = MW'((32'(i_ptr) + k) % NUM_MST);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
    if (!w_found) o_pick[DEF_MST] = 1'b1;
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/ahb_interconnect_arbiter.sv
// Multi-master AHB-Lite arbiter: round-robin grant, burst/lock-aware handover.
module ahb_interconnect_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int MW      = $clog2(NUM_MST),
  parameter int DEF_MST = 0
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_MST-1:0] hbusreq,
  input  logic [NUM_MST-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  output logic [NUM_MST-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_d,
  output logic               hmastlock
);

  localparam logic [NUM_MST-1:0] GRANT_DEF = NUM_MST'(1) << DEF_MST;

  function automatic logic [MW-1:0] onehot2idx(input logic [NUM_MST-1:0] v);
    logic [MW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_MST; k++)
      if (v[k]) r = MW'(k);
    return r;
  endfunction

  arb_state_e         r_state;
  logic [NUM_MST-1:0] r_grant;
  logic [MW-1:0]      r_ptr;
  logic [MW-1:0]      r_hmaster;
  logic [MW-1:0]      r_hmaster_d;
  logic               r_hmastlock;
  logic [3:0]         r_cnt;
  logic               r_undef;

  htrans_e            w_trans;
  hburst_e            w_burst;
  logic [3:0]         w_cnt_n;
  logic               w_undef_n;
  logic [NUM_MST-1:0] w_pick;
  logic               w_any;
  logic [MW-1:0]      w_pidx;
  logic [MW-1:0]      w_gidx;
  logic               w_hold_lock;
  logic               w_arb_raw;
  logic               w_arb_ok;
  logic               w_lock_exit;
  logic               w_rearb;
  logic               w_enter_lock;
  logic               w_mastlock_n;

  assign w_trans = htrans_e'(htrans);
  assign w_burst = hburst_e'(hburst);

  ahb_interconnect_rr_pick #(
    .NUM_MST (NUM_MST),
    .MW      (MW),
    .DEF_MST (DEF_MST)
  ) u_pick (
    .i_req     (hbusreq),
    .i_ptr     (r_ptr),
    .o_pick    (w_pick),
    .o_any_req (w_any)
  );

  // Post-update beat counter and undefined-length flag for this cycle.
  always_comb begin
    w_cnt_n   = r_cnt;
    w_undef_n = r_undef;
    if (hready) begin
      case (w_trans)
        NONSEQ: begin
          w_cnt_n   = burst_beats(w_burst);
          w_undef_n = (w_burst == INCR);
        end
        SEQ:    w_cnt_n = (r_cnt != '0) ? r_cnt - 4'd1 : '0;
        IDLE: begin
          w_cnt_n   = '0;
          w_undef_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_gidx       = onehot2idx(r_grant);
  assign w_pidx       = onehot2idx(w_pick);
  assign w_hold_lock  = (r_state == LOCKED);
  assign w_arb_raw    = hready & ((w_trans == IDLE) | w_undef_n | (w_cnt_n == '0));
  assign w_arb_ok     = w_arb_raw & ~w_hold_lock;
  // A locked owner releasing its lock at a boundary re-arbitrates the same cycle.
  assign w_lock_exit  = w_hold_lock & ~hlock[w_gidx] & w_arb_raw;
  assign w_rearb      = w_arb_ok | w_lock_exit;
  assign w_enter_lock = w_rearb & w_any & hlock[w_pidx];
  assign w_mastlock_n = hlock[w_gidx] & (w_hold_lock | w_enter_lock);

  // Arbiter FSM, grant/pointer, beat counter and address/data-phase owner registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= PARK;
      r_grant     <= GRANT_DEF;
      r_ptr       <= MW'(DEF_MST);
      r_hmaster   <= MW'(DEF_MST);
      r_hmaster_d <= MW'(DEF_MST);
      r_hmastlock <= 1'b0;
      r_cnt       <= '0;
      r_undef     <= 1'b0;
    end else begin
      if (hready) begin
        r_cnt       <= w_cnt_n;
        r_undef     <= w_undef_n;
        r_hmaster   <= w_gidx;
        r_hmaster_d <= r_hmaster;
        r_hmastlock <= w_mastlock_n;
      end
      if (w_rearb) begin
        if (!w_any)             r_state <= PARK;
        else if (hlock[w_pidx]) r_state <= LOCKED;
        else                    r_state <= OWNED;
        if (w_pick != r_grant) begin
          r_grant <= w_pick;
          r_ptr   <= w_pidx;
        end
      end
    end
  end

  assign hgrant    = r_grant;
  assign hmaster   = r_hmaster;
  assign hmaster_d = r_hmaster_d;
  assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_interconnect_arbiter.sv
// Directed bench for ahb_interconnect_arbiter: vector table plus corner sequences.
module tb_ahb_interconnect_arbiter;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_d;
  logic       hmastlock;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  ahb_interconnect_arbiter #(
    .NUM_MST (4),
    .DEF_MST (0)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".hgrant"},    32'(hgrant),    32'h1);
    chk({nm, ".hmaster"},   32'(hmaster),   32'h0);
    chk({nm, ".hmaster_d"}, 32'(hmaster_d), 32'h0);
    chk({nm, ".hmastlock"}, 32'(hmastlock), 32'h0);
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    hresetn = 1'b0;
    tick();
    tick();
    hresetn = 1'b1;
    chk_reset_vals("reset");
  endtask

  initial begin
    tbl[0]  = '{4'b0000, T_IDLE, B_SINGLE, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, T_IDLE, B_SINGLE, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, T_IDLE, B_SINGLE, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[3]  = '{4'b0110, T_IDLE, B_SINGLE, 4'b0010, 2'd0, 2'd0, 1'b0};
    tbl[4]  = '{4'b0110, T_NSEQ, B_SINGLE, 4'b0100, 2'd1, 2'd0, 1'b0};
    tbl[5]  = '{4'b0110, T_NSEQ, B_SINGLE, 4'b0010, 2'd2, 2'd1, 1'b0};
    tbl[6]  = '{4'b0110, T_NSEQ, B_SINGLE, 4'b0100, 2'd1, 2'd2, 1'b0};
    tbl[7]  = '{4'b0110, T_NSEQ, B_SINGLE, 4'b0010, 2'd2, 2'd1, 1'b0};
    tbl[8]  = '{4'b0000, T_NSEQ, B_SINGLE, 4'b0001, 2'd1, 2'd2, 1'b0};
    tbl[9]  = '{4'b0000, T_IDLE, B_SINGLE, 4'b0001, 2'd0, 2'd1, 1'b0};
    tbl[10] = '{4'b0001, T_IDLE, B_SINGLE, 4'b0001, 2'd0, 2'd0, 1'b0};
    tbl[11] = '{4'b0011, T_IDLE, B_SINGLE, 4'b0010, 2'd0, 2'd0, 1'b0};

    hresetn = 1'b0;
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    #2;

    // Parked with no requests for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_reset_vals("park");
    end

    // Vector table: parking, 1/2 rotation, return to park, re-grant.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].req, 4'b0000, tbl[i].trans, tbl[i].burst, 1'b1);
      tick();
      chk($sformatf("vec%0d.hgrant", i),    32'(hgrant),    32'(tbl[i].g));
      chk($sformatf("vec%0d.hmaster", i),   32'(hmaster),   32'(tbl[i].m));
      chk($sformatf("vec%0d.hmaster_d", i), 32'(hmaster_d), 32'(tbl[i].md));
      chk($sformatf("vec%0d.hmastlock", i), 32'(hmastlock), 32'(tbl[i].ml));
    end

    // INCR8 by master 1 with master 3 waiting.
    do_reset();
    drive(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("incr8.grant0", 32'(hgrant), 32'h2);
    drive(4'b1010, 4'b0000, T_NSEQ, B_INCR8, 1'b1);
    tick();
    chk("incr8.nseq_grant", 32'(hgrant), 32'h2);
    chk("incr8.hmaster1", 32'(hmaster), 32'h1);
    for (int i = 0; i < 7; i++) begin
      drive(4'b1010, 4'b0000, T_SEQ, B_INCR8, 1'b1);
      tick();
      chk($sformatf("incr8.seq%0d_grant", i), 32'(hgrant), (i == 6) ? 32'h8 : 32'h2);
    end
    drive(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("incr8.hmaster3", 32'(hmaster), 32'h3);
    chk("incr8.grant3", 32'(hgrant), 32'h8);
    chk("incr8.hmaster_d", 32'(hmaster_d), 32'h1);

    // hready stall in the middle of an INCR4.
    do_reset();
    drive(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    drive(4'b1010, 4'b0000, T_NSEQ, B_INCR4, 1'b1);
    tick();
    drive(4'b1010, 4'b0000, T_SEQ, B_INCR4, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1010, 4'b0000, T_SEQ, B_INCR4, 1'b0);
      tick();
      chk($sformatf("stall%0d.hgrant", i),    32'(hgrant),    32'h2);
      chk($sformatf("stall%0d.hmaster", i),   32'(hmaster),   32'h1);
      chk($sformatf("stall%0d.hmaster_d", i), 32'(hmaster_d), 32'h1);
      chk($sformatf("stall%0d.hmastlock", i), 32'(hmastlock), 32'h0);
    end
    drive(4'b1010, 4'b0000, T_SEQ, B_INCR4, 1'b1);
    tick();
    chk("stall.beat3_grant", 32'(hgrant), 32'h2);
    drive(4'b1010, 4'b0000, T_SEQ, B_INCR4, 1'b1);
    tick();
    chk("stall.beat4_grant", 32'(hgrant), 32'h8);

    // Locked sequence by master 2 with master 0 requesting.
    do_reset();
    drive(4'b0101, 4'b0100, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("lock.grant", 32'(hgrant), 32'h4);
    chk("lock.ml0", 32'(hmastlock), 32'h0);
    drive(4'b0101, 4'b0100, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("lock.hmaster", 32'(hmaster), 32'h2);
    chk("lock.ml_own", 32'(hmastlock), 32'h1);
    for (int i = 0; i < 2; i++) begin
      drive(4'b0101, 4'b0100, T_NSEQ, B_SINGLE, 1'b1);
      tick();
      chk($sformatf("lock.single%0d_grant", i), 32'(hgrant), 32'h4);
      chk($sformatf("lock.single%0d_ml", i), 32'(hmastlock), 32'h1);
    end
    drive(4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("lock.release_grant", 32'(hgrant), 32'h1);
    chk("lock.release_ml", 32'(hmastlock), 32'h0);
    drive(4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("lock.hmaster0", 32'(hmaster), 32'h0);
    chk("lock.grant_kept", 32'(hgrant), 32'h1);

    // Asynchronous reset during an INCR16 owned by master 3.
    do_reset();
    drive(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    drive(4'b1000, 4'b0000, T_NSEQ, B_INCR16, 1'b1);
    tick();
    drive(4'b1000, 4'b0000, T_SEQ, B_INCR16, 1'b1);
    tick();
    tick();
    chk("arst.pre_grant", 32'(hgrant), 32'h8);
    chk("arst.pre_hmaster", 32'(hmaster), 32'h3);
    chk("arst.pre_hmaster_d", 32'(hmaster_d), 32'h3);
    #2;
    hresetn = 1'b0;
    #1;
    chk_reset_vals("arst");
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    hresetn = 1'b1;
    drive(4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    tick();
    chk("arst.restart_grant", 32'(hgrant), 32'h2);
    chk("arst.restart_hmaster", 32'(hmaster), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
